// File: rtl/cpu_types_pkg.sv
// Shared types for the two-core memory bus: RAM handshake,
// bus sequencer states and the core count.
package cpu_types_pkg;
    localparam int CPUS = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        SNOOP,
        RD1,
        RD2,
        FWD1,
        FWD2,
        WB1,
        WB2,
        IF
    } busstate_t;
endpackage

// File: rtl/rr_arbiter.sv
// Two-input round-robin arbiter; pointer remembers the last accepted
// winner and gives the other input priority on the next tie.
module rr_arbiter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant
);
    logic last;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last <= 1'b1;
        end else if (accept && |req) begin
            last <= grant;
        end
    end

    always_comb begin
        grant = req[1] & (~req[0] | ~last);
    end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core bus controller: icache/dcache arbitration and block sequencing.
// Define BUS_SNOOP_EN to add snooping and cache-to-cache forwarding.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  word_t           iaddr       [CPUS],
    output word_t           iload       [CPUS],
    output logic [CPUS-1:0] iwait,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           daddr       [CPUS],
    input  word_t           dstore      [CPUS],
    output word_t           dload       [CPUS],
    output logic [CPUS-1:0] dwait,
    input  logic [CPUS-1:0] cctrans,
    input  logic [CPUS-1:0] ccwrite,
    output logic [CPUS-1:0] ccwait,
    output logic [CPUS-1:0] ccinv,
    output word_t           ccsnoopaddr [CPUS],
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);
    busstate_t state, next_state;
    logic dsel, isel;
    logic dgrant, igrant;
    logic darb_acc, iacc;
    logic acc;

    assign acc      = (ramstate == ACCESS);
    assign darb_acc = (state == ARB);
    assign iacc     = (state == IDLE) && !(|cctrans);

    rr_arbiter u_darb (
        .CLK    (CLK),
        .nRST   (nRST),
        .req    (cctrans),
        .accept (darb_acc),
        .grant  (dgrant)
    );

    rr_arbiter u_iarb (
        .CLK    (CLK),
        .nRST   (nRST),
        .req    (iREN),
        .accept (iacc),
        .grant  (igrant)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            dsel  <= 1'b0;
            isel  <= 1'b0;
        end else begin
            state <= next_state;
            if (darb_acc) dsel <= dgrant;
            if (iacc) isel <= igrant;
        end
    end

`ifdef BUS_SNOOP_EN
    logic other;
    logic snoop_second;

    assign other = ~dsel;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            snoop_second <= 1'b0;
        end else begin
            snoop_second <= (state == SNOOP) && !snoop_second;
        end
    end
`else
    logic unused_ccwrite;
    assign unused_ccwrite = |ccwrite;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (|cctrans) next_state = ARB;
                else if (|iREN) next_state = IF;
            end
            ARB: begin
                if (dWEN[dgrant]) next_state = WB1;
`ifdef BUS_SNOOP_EN
                else if (dREN[dgrant]) next_state = SNOOP;
`else
                else if (dREN[dgrant]) next_state = RD1;
`endif
                else next_state = IDLE;
            end
`ifdef BUS_SNOOP_EN
            SNOOP: begin
                if (snoop_second) begin
                    if (cctrans[other] && ccwrite[other]) next_state = FWD1;
                    else next_state = RD1;
                end
            end
            FWD1: if (acc) next_state = FWD2;
            FWD2: if (acc) next_state = IDLE;
`endif
            RD1: if (acc) next_state = RD2;
            RD2: if (acc) next_state = IDLE;
            WB1: if (acc) next_state = WB2;
            WB2: if (acc) next_state = IDLE;
            IF:  if (acc) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int k = 0; k < CPUS; k++) begin
            iload[k]       = '0;
            dload[k]       = '0;
            ccsnoopaddr[k] = '0;
        end
`ifdef BUS_SNOOP_EN
        // The snooped core stays stalled until the forward completes.
        if (state inside {SNOOP, FWD1, FWD2}) begin
            ccwait[other]      = 1'b1;
            ccinv[other]       = ccwrite[dsel];
            ccsnoopaddr[other] = daddr[dsel];
        end
`endif
        unique case (state)
            IF: begin
                ramREN      = 1'b1;
                ramaddr     = iaddr[isel];
                iload[isel] = ramload;
                iwait[isel] = !acc;
            end
            RD1, RD2: begin
                ramREN      = 1'b1;
                ramaddr     = daddr[dsel];
                dload[dsel] = ramload;
                dwait[dsel] = !acc;
            end
            WB1, WB2: begin
                ramWEN      = 1'b1;
                ramaddr     = daddr[dsel];
                ramstore    = dstore[dsel];
                dwait[dsel] = !acc;
            end
`ifdef BUS_SNOOP_EN
            FWD1, FWD2: begin
                ramWEN       = 1'b1;
                ramaddr      = daddr[dsel];
                ramstore     = dstore[other];
                dload[dsel]  = dstore[other];
                dwait[dsel]  = !acc;
                dwait[other] = !acc;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: vector table of single
// transactions plus multi-cycle sequences (tie, IF overlap, reset, forward).
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

`ifdef BUS_SNOOP_EN
    localparam int RDLAT = 5;
`else
    localparam int RDLAT = 3;
`endif

    logic            CLK = 1'b0;
    logic            nRST;
    logic [CPUS-1:0] iREN, iwait, dREN, dWEN, dwait;
    logic [CPUS-1:0] cctrans, ccwrite, ccwait, ccinv;
    word_t           iaddr [CPUS], iload [CPUS];
    word_t           daddr [CPUS], dstore [CPUS], dload [CPUS];
    word_t           ccsnoopaddr [CPUS];
    logic            ramREN, ramWEN;
    word_t           ramaddr, ramstore, ramload;
    ramstate_t       ramstate;

    word_t mem [0:4095];
    int    stall_cnt = 0;
    int    wait_cycles = 0;
    bit    err_mode = 0;
    int    checks = 0;
    int    errors = 0;

    coherence_bus_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iload       (iload),
        .iwait       (iwait),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .dload       (dload),
        .dwait       (dwait),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM model: wait_cycles stall cycles per word, then ACCESS
    always_comb begin
        if (!(ramREN || ramWEN)) ramstate = FREE;
        else if (stall_cnt >= wait_cycles) ramstate = ACCESS;
        else ramstate = err_mode ? ERROR : BUSY;
    end

    assign ramload = mem[ramaddr[13:2]];

    always @(posedge CLK) begin
        if (ramWEN && ramstate == ACCESS) mem[ramaddr[13:2]] <= ramstore;
        if ((ramREN || ramWEN) && ramstate != ACCESS) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for iwait (kind 0) or dwait of core c to go low.
    task automatic wait_lo(input int kind, input int c, output int cyc,
                           output word_t data);
        bit done;
        done = 0;
        cyc  = 0;
        data = '0;
        for (int t = 1; t <= 40 && !done; t++) begin
            @(negedge CLK);
            if (kind == 0 ? !iwait[c] : !dwait[c]) begin
                cyc  = t;
                data = (kind == 0) ? iload[c] : dload[c];
                done = 1;
            end else begin
                tick();
            end
        end
    endtask

    typedef struct {
        int    kind;
        int    core;
        word_t addr;
        word_t d0;
        word_t d1;
        int    waitc;
        bit    err;
        int    lat;
    } vec_t;

    vec_t  vec [8];
    int    cyc, wc, idone, dfirst;
    word_t d, snaddr, id;
    word_t got [2];
    int    order [$];
    bit    snseen, bad;

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 32'hA500_0000 | k;

        vec[0] = '{0, 0, 32'h0040, 32'hA500_0010, 32'h0, 0, 0, 2};
        vec[1] = '{0, 1, 32'h0044, 32'hA500_0011, 32'h0, 1, 0, 3};
        vec[2] = '{1, 0, 32'h1000, 32'hA500_0400, 32'hA500_0401, 0, 0, RDLAT};
        vec[3] = '{2, 1, 32'h3000, 32'h1111_2222, 32'h3333_4444, 3, 0, 6};
        vec[4] = '{1, 0, 32'h3000, 32'h1111_2222, 32'h3333_4444, 1, 0, RDLAT + 1};
        vec[5] = '{0, 0, 32'h0040, 32'hA500_0010, 32'h0, 2, 1, 4};
        vec[6] = '{2, 0, 32'h2010, 32'hCAFE_0001, 32'hCAFE_0002, 0, 0, 3};
        vec[7] = '{1, 1, 32'h2010, 32'hCAFE_0001, 32'hCAFE_0002, 2, 1, RDLAT + 2};

        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        for (int k = 0; k < CPUS; k++) begin
            iaddr[k] = '0; daddr[k] = '0; dstore[k] = '0;
        end
        #3;
        check("rst_iwait", 32'(iwait), 32'h3);
        check("rst_dwait", 32'(dwait), 32'h3);
        check("rst_ccwait", 32'(ccwait), 32'h0);
        check("rst_ccinv", 32'(ccinv), 32'h0);
        check("rst_ramREN", 32'(ramREN), 32'h0);
        check("rst_ramWEN", 32'(ramWEN), 32'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_iload0", iload[0], 32'h0);
        check("rst_dload1", dload[1], 32'h0);
        check("rst_snoopaddr0", ccsnoopaddr[0], 32'h0);
        tick();
        tick();
        nRST = 1'b1;
        tick();

        for (int n = 0; n < 8; n++) begin
            automatic int c = vec[n].core;
            wait_cycles = vec[n].waitc;
            err_mode    = vec[n].err;
            if (vec[n].kind == 0) begin
                iREN[c]  = 1'b1;
                iaddr[c] = vec[n].addr;
                wait_lo(0, c, cyc, d);
                check($sformatf("v%0d_if_lat", n), 32'(cyc), 32'(vec[n].lat));
                check($sformatf("v%0d_iload", n), d, vec[n].d0);
                tick();
                iREN[c] = 1'b0;
            end else begin
                cctrans[c] = 1'b1;
                dREN[c]    = (vec[n].kind == 1);
                dWEN[c]    = (vec[n].kind == 2);
                daddr[c]   = vec[n].addr;
                dstore[c]  = vec[n].d0;
                wait_lo(1, c, cyc, d);
                check($sformatf("v%0d_lat0", n), 32'(cyc), 32'(vec[n].lat));
                if (vec[n].kind == 1) check($sformatf("v%0d_w0", n), d, vec[n].d0);
                tick();
                daddr[c]  = vec[n].addr + 4;
                dstore[c] = vec[n].d1;
                wait_lo(1, c, cyc, d);
                check($sformatf("v%0d_lat1", n), 32'(cyc), 32'(1 + vec[n].waitc));
                if (vec[n].kind == 1) check($sformatf("v%0d_w1", n), d, vec[n].d1);
                tick();
                cctrans[c] = 1'b0; dREN[c] = 1'b0; dWEN[c] = 1'b0;
                if (vec[n].kind == 2) begin
                    check($sformatf("v%0d_mem0", n), mem[vec[n].addr[13:2]], vec[n].d0);
                    check($sformatf("v%0d_mem1", n), mem[vec[n].addr[13:2] + 1], vec[n].d1);
                end
            end
            tick();
        end
        wait_cycles = 0;
        err_mode    = 0;

        // Simultaneous read misses: core 0 wins the first tie
        cctrans = 2'b11; dREN = 2'b11;
        daddr[0] = 32'h1000; daddr[1] = 32'h1010;
        wc = 0; snseen = 0; snaddr = '0;
        begin
            automatic int cnt [2] = '{0, 0};
            automatic word_t w [4];
            for (int t = 0; t < 60 && (cnt[0] < 2 || cnt[1] < 2); t++) begin
                @(negedge CLK);
                if (ccwait[1] && !snseen) begin snaddr = ccsnoopaddr[1]; snseen = 1; end
                for (int c = 0; c < 2; c++) begin
                    if (!dwait[c]) begin
                        order.push_back(c);
                        w[c * 2 + cnt[c]] = dload[c];
                        cnt[c]++;
                    end
                end
                tick();
                for (int c = 0; c < 2; c++) begin
                    if (cnt[c] == 1) daddr[c] = (c == 0) ? 32'h1004 : 32'h1014;
                    if (cnt[c] == 2) begin cctrans[c] = 1'b0; dREN[c] = 1'b0; end
                end
            end
            check("tie_nwords", 32'(order.size()), 32'd4);
            for (int k = 0; k < 4 && k < order.size(); k++)
                check($sformatf("tie_order%0d", k), 32'(order[k]), 32'(k / 2));
            check("tie_c0w0", w[0], 32'hA500_0400);
            check("tie_c0w1", w[1], 32'hA500_0401);
            check("tie_c1w0", w[2], 32'hA500_0404);
            check("tie_c1w1", w[3], 32'hA500_0405);
`ifdef BUS_SNOOP_EN
            check("tie_snoopaddr1", snaddr, 32'h1000);
`endif
        end
        cctrans = '0; dREN = '0;
        tick();

        // Dcache request arrives while an ifetch is in flight
        wait_cycles = 2;
        iREN[0] = 1'b1; iaddr[0] = 32'h0040;
        tick();
        cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h1008;
        idone = 0; wc = 0; bad = 0; id = '0; dfirst = 0;
        for (int t = 2; t < 60 && wc < 2; t++) begin
            @(negedge CLK);
            if (!iwait[0] && idone == 0) begin idone = t; id = iload[0]; end
            if (!dwait[1]) begin
                if (idone == 0) bad = 1;
                if (wc == 0) dfirst = t;
                got[wc] = dload[1];
                wc++;
            end
            tick();
            if (idone != 0) iREN[0] = 1'b0;
            if (wc == 1) daddr[1] = 32'h100C;
            if (wc == 2) begin cctrans[1] = 1'b0; dREN[1] = 1'b0; end
        end
        check("ifov_if_lat", 32'(idone), 32'd4);
        check("ifov_iload", id, 32'hA500_0010);
        check("ifov_d_after_if", 32'(bad), 32'd0);
        check("ifov_d_lat", 32'(dfirst), 32'(4 + RDLAT + 2));
        check("ifov_w0", got[0], 32'hA500_0402);
        check("ifov_w1", got[1], 32'hA500_0403);
        iREN = '0; cctrans = '0; dREN = '0;
        tick();

        // Asynchronous reset while the read is stalled in RD1
        wait_cycles = 5;
        cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h1000;
        begin
            automatic bit seen = 0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge CLK);
                if (ramREN) seen = 1;
            end
            check("rst_mid_reached_rd", 32'(seen), 32'd1);
        end
        #2;
        nRST = 1'b0;
        #1;
        check("rst_mid_ramREN", 32'(ramREN), 32'h0);
        check("rst_mid_ramaddr", ramaddr, 32'h0);
        check("rst_mid_dwait", 32'(dwait), 32'h3);
        check("rst_mid_ccwait", 32'(ccwait), 32'h0);
        check("rst_mid_dload0", dload[0], 32'h0);
        cctrans = '0; dREN = '0;
        wait_cycles = 0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
        cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h1018;
        wait_lo(1, 1, cyc, d);
        check("post_rst_lat", 32'(cyc), 32'(RDLAT));
        check("post_rst_w0", d, 32'hA500_0406);
        tick();
        daddr[1] = 32'h101C;
        wait_lo(1, 1, cyc, d);
        check("post_rst_w1", d, 32'hA500_0407);
        tick();
        cctrans = '0; dREN = '0;
        tick();

`ifdef BUS_SNOOP_EN
        // Read-exclusive miss forwarded from core 1's dirty copy
        cctrans[0] = 1'b1; dREN[0] = 1'b1; ccwrite[0] = 1'b1;
        daddr[0] = 32'h2000;
        begin
            automatic bit answered = 0;
            automatic bit inv_seen = 0;
            automatic bit j_ok = 1;
            automatic bit cw_seen = 0;
            automatic int lat = 0;
            wc = 0; snseen = 0; snaddr = '0;
            for (int t = 1; t < 40 && wc < 2; t++) begin
                @(negedge CLK);
                cw_seen = ccwait[1];
                if (ccwait[1]) begin
                    inv_seen |= ccinv[1];
                    if (!snseen) begin snaddr = ccsnoopaddr[1]; snseen = 1; end
                end
                if (!dwait[0]) begin
                    if (wc == 0) lat = t;
                    got[wc] = dload[0];
                    if (dwait[1] || !ccwait[1]) j_ok = 0;
                    wc++;
                end
                tick();
                if (cw_seen && !answered) begin
                    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dWEN[1] = 1'b1;
                    dstore[1] = 32'h0000_AAAA; answered = 1;
                end
                if (wc == 1) begin daddr[0] = 32'h2004; dstore[1] = 32'h0000_BBBB; end
                if (wc == 2) begin
                    cctrans = '0; dREN = '0; dWEN = '0; ccwrite = '0;
                end
            end
            check("fwd_lat", 32'(lat), 32'd5);
            check("fwd_ccinv1", 32'(inv_seen), 32'd1);
            check("fwd_snoopaddr1", snaddr, 32'h2000);
            check("fwd_core1_ack", 32'(j_ok), 32'd1);
            check("fwd_w0", got[0], 32'h0000_AAAA);
            check("fwd_w1", got[1], 32'h0000_BBBB);
            check("fwd_mem0", mem[12'h800], 32'h0000_AAAA);
            check("fwd_mem1", mem[12'h801], 32'h0000_BBBB);
        end
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
